mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter_pkg.sv | 25 ++
 rtl/mode_counter_prescaler.sv | 34 +++
 rtl/mode_counter.sv | 162 ++++++++++++++++
 tb/tb_mode_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
// Shared types and defaults for the mode_counter block: mode encoding,
// PINGPONG direction state and ONESHOT run state.
package mode_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_PRE_W = 4;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UPW = 1'b0,
    DIR_DNW = 1'b1
  } dir_state_e;

  typedef enum logic {
    OS_RUN  = 1'b0,
    OS_HALT = 1'b1
  } os_state_e;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Enable-gated prescaler: tick fires on the enabled cycle where the internal
// count matches prescale, then the count restarts from zero.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clear,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = (r_cnt == prescale);
  assign tick  = en && w_hit;

  // NOTE: reset is sampled on the clock edge only, so rst_n stays out of the
  // sensitivity list; state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter (UP / DOWN / PINGPONG / ONESHOT) with load, inclusive
// limit, prescaled ticks and registered count, tc, dir and done outputs.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir,
  output logic             done
);

  mode_e            w_mode;
  logic             w_tick;
  dir_state_e       r_dir_st, w_dir_st_nxt;
  os_state_e        r_os_st, w_os_st_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] w_count_inc, w_count_dec, w_lim_m1, w_turn_up;
  logic             w_at_top, w_at_zero, w_os_term;

  assign w_mode      = mode_e'(mode);
  assign w_count_inc = r_count + 1'b1;
  assign w_count_dec = r_count - 1'b1;
  assign w_at_top    = (r_count >= limit);
  assign w_at_zero   = (r_count == '0);
  // PINGPONG turn-around targets collapse to 0 when the range is a single value.
  assign w_lim_m1    = (limit == '0) ? '0 : limit - 1'b1;
  assign w_turn_up   = (limit == '0) ? '0 : WIDTH'(1);
  assign w_os_term   = w_at_top || (w_count_inc == limit);

  mode_counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .prescale (prescale),
    .clear    (load),
    .tick     (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir_st <= DIR_UPW;
      r_os_st  <= OS_RUN;
      r_count  <= '0;
      r_tc     <= 1'b0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_dir_st <= w_dir_st_nxt;
      r_os_st  <= w_os_st_nxt;
      r_count  <= w_count_nxt;
      r_tc     <= w_tc_nxt;
      r_dir    <= w_dir_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_dir_st_nxt = r_dir_st;
    w_os_st_nxt  = r_os_st;
    if (load) begin
      w_os_st_nxt = OS_RUN;
    end else begin
      if (w_mode != MODE_PINGPONG) w_dir_st_nxt = DIR_UPW;
      if (w_mode != MODE_ONESHOT)  w_os_st_nxt  = OS_RUN;
      if (w_tick) begin
        case (w_mode)
          MODE_PINGPONG: begin
            if (r_dir_st == DIR_UPW) begin
              if (w_at_top) w_dir_st_nxt = DIR_DNW;
            end else if (w_at_zero) begin
              w_dir_st_nxt = DIR_UPW;
            end
          end
          MODE_ONESHOT: begin
            if (r_os_st == OS_RUN && w_os_term) w_os_st_nxt = OS_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_dir_nxt   = r_dir;
    if (load) begin
      w_count_nxt = load_val;
      w_done_nxt  = 1'b0;
    end else begin
      if (w_mode != MODE_ONESHOT) w_done_nxt = 1'b0;
      w_dir_nxt = (w_mode == MODE_PINGPONG) ? (w_dir_st_nxt == DIR_DNW)
                                            : (w_mode == MODE_DOWN);
      if (w_tick) begin
        case (w_mode)
          MODE_UP: begin
            if (w_at_top) begin
              w_count_nxt = '0;
              w_tc_nxt    = 1'b1;
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
          MODE_DOWN: begin
            if (w_at_zero) begin
              w_count_nxt = limit;
              w_tc_nxt    = 1'b1;
            end else if (r_count > limit) begin
              w_count_nxt = limit;
            end else begin
              w_count_nxt = w_count_dec;
            end
          end
          MODE_PINGPONG: begin
            if (r_dir_st == DIR_UPW) begin
              w_count_nxt = w_at_top ? w_lim_m1 : w_count_inc;
              w_tc_nxt    = w_at_top;
            end else begin
              w_count_nxt = w_at_zero ? w_turn_up : w_count_dec;
              w_tc_nxt    = w_at_zero;
            end
          end
          MODE_ONESHOT: begin
            if (r_os_st == OS_RUN) begin
              if (w_os_term) begin
                w_count_nxt = limit;
                w_tc_nxt    = 1'b1;
                w_done_nxt  = 1'b1;
              end else begin
                w_count_nxt = w_count_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign dir   = r_dir;
  assign done  = r_done;

endmodule

// File: tb/tb_mode_counter.sv
// Randomized scoreboard bench for mode_counter with a behavioural reference
// model plus short directed sequences with literal expectations.
module tb_mode_counter;
  import mode_counter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       dir;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;
  int n_cyc    = 0;

  logic [10:0] exp_q[$];

  // reference model state (plain integers, rule-by-rule from the mode definitions)
  int m_count, m_pre, m_dnw, m_halt, m_done, m_tc, m_dir;

  mode_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .dir      (dir),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit tick;
    int lim;
    lim  = int'(limit);
    m_tc = 0;
    if (!rst_n) begin
      m_count = 0; m_pre = 0; m_dnw = 0; m_halt = 0; m_done = 0; m_dir = 0;
    end else begin
      tick = en && (m_pre == int'(prescale));
      if (load)    m_pre = 0;
      else if (en) m_pre = tick ? 0 : (m_pre + 1) % 16;
      if (load) begin
        m_count = int'(load_val);
        m_done  = 0;
        m_halt  = 0;
      end else begin
        if (mode != 2'd2) m_dnw = 0;
        if (mode != 2'd3) begin m_done = 0; m_halt = 0; end
        if (tick) begin
          case (mode)
            2'd0: begin
              if (m_count < lim) m_count++;
              else begin m_count = 0; m_tc = 1; end
            end
            2'd1: begin
              if (m_count == 0) begin m_count = lim; m_tc = 1; end
              else if (m_count > lim) m_count = lim;
              else m_count--;
            end
            2'd2: begin
              if (m_dnw == 0) begin
                if (m_count < lim) m_count++;
                else begin m_count = (lim == 0) ? 0 : lim - 1; m_dnw = 1; m_tc = 1; end
              end else begin
                if (m_count > 0) m_count--;
                else begin m_count = (lim == 0) ? 0 : 1; m_dnw = 0; m_tc = 1; end
              end
            end
            default: begin
              if (m_halt == 0) begin
                if (m_count >= lim) m_count = lim;
                else m_count++;
                if (m_count == lim) begin m_halt = 1; m_done = 1; m_tc = 1; end
              end
            end
          endcase
        end
        m_dir = (mode == 2'd2) ? m_dnw : ((mode == 2'd1) ? 1 : 0);
      end
    end
    exp_q.push_back({8'(m_count), 1'(m_tc), 1'(m_dir), 1'(m_done)});
  endtask

  task automatic drive(input int r, input int e, input int m, input int l,
                       input int lv, input int lim, input int ps);
    @(negedge clk);
    rst_n    = 1'(r);
    en       = 1'(e);
    mode     = 2'(m);
    load     = 1'(l);
    load_val = 8'(lv);
    limit    = 8'(lim);
    prescale = 4'(ps);
    model_step();
  endtask

  // monitor: the DUT presents a fresh registered output every cycle
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cyc++;
        check($sformatf("sb cyc%0d {count,tc,dir,done}", n_cyc),
              32'({count, tc, dir, done}), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int up_exp[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int dn_exp[5] = '{3, 2, 1, 0, 3};
    int pp_cnt[7] = '{1, 2, 3, 2, 1, 0, 1};
    int pp_dir[7] = '{0, 0, 0, 1, 1, 1, 0};
    int mode_r, lim_r, ps_r, lv_r;

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0;
    load_val = '0; limit = '0; prescale = '0;

    // UP, limit 5: wraps to 0 with tc
    drive(0, 0, 0, 0, 0, 5, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0, 5, 0);
      @(posedge clk); #1;
      check("up_count", 32'(count), 32'(up_exp[i]));
      check("up_tc", 32'(tc), 32'(i == 5));
    end

    // DOWN, limit 3: load 9 clamps to 3 without tc, then wraps at 0
    drive(0, 0, 0, 0, 0, 3, 0);
    drive(1, 0, 1, 1, 9, 3, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 3, 0);
      @(posedge clk); #1;
      check("dn_count", 32'(count), 32'(dn_exp[i]));
      check("dn_tc", 32'(tc), 32'(i == 4));
    end

    // PINGPONG, limit 3
    drive(0, 0, 2, 0, 0, 3, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 2, 0, 0, 3, 0);
      @(posedge clk); #1;
      check("pp_count", 32'(count), 32'(pp_cnt[i]));
      check("pp_dir", 32'(dir), 32'(pp_dir[i]));
      check("pp_tc", 32'(tc), 32'(i == 3 || i == 6));
    end

    // reset mid-PINGPONG at count=2 dir=1, with load and en also asserted
    drive(0, 0, 2, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 2, 0, 0, 3, 0);
    drive(0, 1, 2, 1, 77, 3, 0);
    @(posedge clk); #1;
    check("rst_state", 32'({count, tc, dir, done}), 32'(0));
    drive(1, 1, 2, 0, 0, 3, 0);
    @(posedge clk); #1;
    check("rst_resume", 32'(count), 32'(1));

    // ONESHOT, limit 4, prescale 2: halts at 4, then reload restarts
    drive(0, 0, 3, 0, 0, 4, 2);
    for (int i = 0; i < 16; i++) drive(1, 1, 3, 0, 0, 4, 2);
    @(posedge clk); #1;
    check("os_done", 32'({count, done}), 32'({8'd4, 1'b1}));
    drive(1, 1, 3, 1, 0, 4, 2);
    for (int i = 0; i < 8; i++) drive(1, 1, 3, 0, 0, 4, 2);

    // UP, limit 255: load collides with a tick, then en low freezes
    drive(0, 0, 0, 0, 0, 255, 3);
    for (int i = 0; i < 7; i++) drive(1, 1, 0, 0, 0, 255, 3);
    drive(1, 1, 0, 1, 200, 255, 3);
    @(posedge clk); #1;
    check("load_vs_tick", 32'(count), 32'(200));
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 255, 3);
    @(posedge clk); #1;
    check("en_freeze", 32'(count), 32'(200));
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 0, 255, 3);

    // randomized traffic across modes, limits and prescales
    mode_r = 0; lim_r = 6; ps_r = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 4) mode_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 3))
          0:       lim_r = 0;
          1:       lim_r = 255;
          default: lim_r = int'($urandom_range(1, 12));
        endcase
      end
      if ($urandom_range(0, 99) < 3) ps_r = int'($urandom_range(0, 3));
      lv_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) >= 2) ? 1 : 0,
            ($urandom_range(0, 99) < 80) ? 1 : 0,
            mode_r,
            ($urandom_range(0, 99) < 8) ? 1 : 0,
            lv_r, lim_r, ps_r);
    end

    @(posedge clk); #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
